// File: rtl/f33m_mult_arb.sv
// f33m_mult_arb
// Shares one f33m multiplier among three requesters.
// A round-robin arbiter picks the winner while the block is IDLE. The winner's
// operand pair is latched once, then the block walks START -> RUN -> RESP.
// RESP returns the result together with a one-cycle ack pulse. A watchdog ends
// any RUN phase that lasts TMO cycles without mult_done, and it flags err.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous reset, active low (0 = reset)
//   req[2:0]     level request per requester
//   a0..b2       operand pair of each requester
//   ack[2:0]     one-hot completion pulse (RESP cycle)
//   c            product register, valid in the ack cycle, held until next ack
//   grant[2:0]   one-hot current owner, 0 when idle
//   busy         high whenever not IDLE
//   err          sticky watchdog-timeout flag
//   mult_reset   start/reset to the multiplier (high in IDLE and START)
//   mult_a/b     latched operands to the multiplier
//   mult_c       multiplier result
//   mult_done    multiplier done level (only looked at in RUN)

`ifndef W3
`define W3 15
`endif

module f33m_mult_arb #(
  parameter logic [15:0] TMO = 16'd4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [`W3:0]  a0,
  input  logic [`W3:0]  b0,
  input  logic [`W3:0]  a1,
  input  logic [`W3:0]  b1,
  input  logic [`W3:0]  a2,
  input  logic [`W3:0]  b2,
  output logic [2:0]    ack,
  output logic [`W3:0]  c,
  output logic [2:0]    grant,
  output logic          busy,
  output logic          err,
  output logic          mult_reset,
  output logic [`W3:0]  mult_a,
  output logic [`W3:0]  mult_b,
  input  logic [`W3:0]  mult_c,
  input  logic          mult_done
);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [2:0]    grant_q, grant_d;
  logic [`W3:0]  c_q, c_d;
  logic [`W3:0]  a_q, a_d;
  logic [`W3:0]  b_q, b_d;
  logic          err_q, err_d;
  // Counts the two START cycles, and it is cleared again on RUN entry to
  // serve as the watchdog counter.
  logic [15:0]   cnt_q, cnt_d;

  logic [1:0]    win;
  logic          win_vld;
  logic [1:0]    idx;
  logic [`W3:0]  sel_a, sel_b;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // The scan runs from lowest to highest priority. A later hit overwrites an
  // earlier one, so the requester at ptr wins if it is asking.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx = rr_idx(ptr_q, k[1:0]);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = a0;
    sel_b = b0;
    case (win)
      2'd1:    begin sel_a = a1; sel_b = b1; end
      2'd2:    begin sel_a = a2; sel_b = b2; end
      default: begin sel_a = a0; sel_b = b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = 3'b001 << win;
          a_d     = sel_a;
          b_d     = sel_b;
          cnt_d   = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = 16'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        // c is loaded on the way into RESP so it is already valid with ack.
        if (mult_done) begin
          c_d     = mult_c;
          state_d = RESP;
        end else if (cnt_q == TMO) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        case (grant_q)
          3'b001:  ptr_d = 2'd1;
          3'b010:  ptr_d = 2'd2;
          default: ptr_d = 2'd0;
        endcase
        grant_d = 3'b000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 3'b000;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack        = (state_q == RESP) ? grant_q : 3'b000;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign mult_reset = (state_q == IDLE) || (state_q == START);
  assign c          = c_q;
  assign err        = err_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;

endmodule
